// File: rtl/lb_pkg.sv
// Shared defaults and helpers for the line window buffer.
// Covers width clamping and the mapping from column slice to RAM bank.
package lb_pkg;

    localparam int unsigned LB_DATA_W = 8;
    localparam int unsigned LB_MAX_W  = 255;
    localparam int unsigned LB_LINES  = 3;

    // A width of 0, or one wider than the RAM, selects the full RAM depth.
    function automatic int unsigned clamp_width(input int unsigned cfg,
                                                input int unsigned max_w);
        if (cfg == 0 || cfg > max_w) begin
            return max_w;
        end
        return cfg;
    endfunction

    // Bank that holds the row k lines above the current one: (wp - k) mod banks.
    function automatic int unsigned bank_of_slice(input int unsigned wp,
                                                  input int unsigned k,
                                                  input int unsigned banks);
        return (wp + banks - (k % banks)) % banks;
    endfunction

endpackage

// File: rtl/lb_ram_bank.sv
// Single-port line RAM with a registered read port.
// A write to the addressed word returns the old contents on the same edge.
module lb_ram_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_W  = 255,
    parameter int unsigned ADDR_W = $clog2(MAX_W)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Streaming line buffer: for each accepted pixel emits the column of LINES pixels
// at the same x, built from LINES-1 rotating line RAMs.
module line_window_buffer
    import lb_pkg::*;
#(
    parameter int unsigned DATA_W = LB_DATA_W,
    parameter int unsigned MAX_W  = LB_MAX_W,
    parameter int unsigned LINES  = LB_LINES,
    parameter int unsigned ADDR_W = $clog2(MAX_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W:0]         cfg_width,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    output logic [LINES*DATA_W-1:0] out_col,
    output logic [ADDR_W-1:0]       out_x,
    output logic                    out_sol,
    output logic                    out_eol,
    output logic                    rows_ready
);

    localparam int unsigned BANKS = LINES - 1;
    localparam int unsigned WP_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned RF_W  = $clog2(LINES);
    localparam int unsigned WW    = ADDR_W + 1;

    // Frame position state
    logic [ADDR_W-1:0] x_q, x_d, x_cur;
    logic [WW-1:0]     width_q, width_d, width_cur;
    logic [WP_W-1:0]   wp_q, wp_d, wp_cur;
    logic [RF_W-1:0]   rf_q, rf_d, rf_cur;
    logic              last;

    // Context of the column currently on the output
    logic              valid_q;
    logic [DATA_W-1:0] col_data_q;
    logic [WP_W-1:0]   col_wp_q;
    logic [RF_W-1:0]   col_rf_q;
    logic [ADDR_W-1:0] col_x_q;
    logic              col_sol_q;
    logic              col_eol_q;

    logic [DATA_W-1:0] rd_data [BANKS];
    logic [WP_W-1:0]   bank_sel;

    // start takes effect in its own cycle so a pixel arriving with it lands at x=0.
    always_comb begin
        width_cur = start ? WW'(clamp_width(32'(cfg_width), MAX_W)) : width_q;
        x_cur     = start ? '0 : x_q;
        wp_cur    = start ? '0 : wp_q;
        rf_cur    = start ? '0 : rf_q;
        last      = ({1'b0, x_cur} == (width_cur - WW'(1)));

        x_d     = x_cur;
        width_d = width_cur;
        wp_d    = wp_cur;
        rf_d    = rf_cur;
        if (in_valid) begin
            if (last) begin
                x_d  = '0;
                wp_d = (wp_cur == WP_W'(BANKS - 1)) ? '0 : wp_cur + WP_W'(1);
                rf_d = (rf_cur == RF_W'(BANKS)) ? rf_cur : rf_cur + RF_W'(1);
            end else begin
                x_d = x_cur + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            width_q <= WW'(MAX_W);
            wp_q    <= '0;
            rf_q    <= '0;
        end else begin
            x_q     <= x_d;
            width_q <= width_d;
            wp_q    <= wp_d;
            rf_q    <= rf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            col_data_q <= '0;
            col_wp_q   <= '0;
            col_rf_q   <= '0;
            col_x_q    <= '0;
            col_sol_q  <= 1'b0;
            col_eol_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                col_data_q <= in_data;
                col_wp_q   <= wp_cur;
                col_rf_q   <= rf_cur;
                col_x_q    <= x_cur;
                col_sol_q  <= (x_cur == '0);
                col_eol_q  <= last;
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        lb_ram_bank #(
            .DATA_W (DATA_W),
            .MAX_W  (MAX_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .en    (in_valid),
            .we    (in_valid && (wp_cur == WP_W'(b))),
            .addr  (x_cur),
            .wdata (in_data),
            .rdata (rd_data[b])
        );
    end

    // Rows not yet written since the frame began read as zero.
    always_comb begin
        out_col               = '0;
        bank_sel              = '0;
        out_col[DATA_W-1:0]   = col_data_q;
        for (int unsigned k = 1; k < LINES; k++) begin
            bank_sel = WP_W'(bank_of_slice(32'(col_wp_q), k, BANKS));
            if (32'(col_rf_q) >= k) begin
                out_col[k*DATA_W +: DATA_W] = rd_data[bank_sel];
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_x      = col_x_q;
    assign out_sol    = col_sol_q;
    assign out_eol    = col_eol_q;
    assign rows_ready = (col_rf_q == RF_W'(BANKS));

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with DATA_W=8, MAX_W=8, LINES=3.
module tb_line_window_buffer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_W  = 8;
    localparam int unsigned LINES  = 3;
    localparam int unsigned ADDR_W = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [ADDR_W:0]         cfg_width;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    out_valid;
    logic [LINES*DATA_W-1:0] out_col;
    logic [ADDR_W-1:0]       out_x;
    logic                    out_sol;
    logic                    out_eol;
    logic                    rows_ready;

    int n_cmp = 0;
    int n_bad = 0;

    line_window_buffer #(
        .DATA_W (DATA_W),
        .MAX_W  (MAX_W),
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_x      (out_x),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .rows_ready (rows_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Column for the p-th pixel (1-based) of a contiguous stream at width w.
    function automatic logic [23:0] exp_col(input int p, input int w);
        int line;
        int s1;
        int s2;
        line = (p - 1) / w;
        s1   = (line >= 1) ? p - w : 0;
        s2   = (line >= 2) ? p - 2 * w : 0;
        return {8'(s2), 8'(s1), 8'(p)};
    endfunction

    task automatic push(input int d, input bit st, input int cfg);
        @(negedge clk);
        start     = st;
        cfg_width = 4'(cfg);
        in_valid  = 1'b1;
        in_data   = 8'(d);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int cfg);
        @(negedge clk);
        start     = 1'b1;
        cfg_width = 4'(cfg);
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_col(input string tag, input int p, input int w);
        int x;
        x = (p - 1) % w;
        check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, " col"}, 32'(out_col), 32'(exp_col(p, w)));
        check_eq({tag, " x"}, 32'(out_x), 32'(x));
        check_eq({tag, " sol"}, 32'(out_sol), 32'(x == 0));
        check_eq({tag, " eol"}, 32'(out_eol), 32'(x == w - 1));
        check_eq({tag, " rows_ready"}, 32'(rows_ready), 32'((p - 1) / w >= 2));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_width = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        #12;
        check_eq("rst valid", 32'(out_valid), 32'd0);
        check_eq("rst col", 32'(out_col), 32'd0);
        check_eq("rst x", 32'(out_x), 32'd0);
        check_eq("rst sol", 32'(out_sol), 32'd0);
        check_eq("rst eol", 32'(out_eol), 32'd0);
        check_eq("rst rows_ready", 32'(rows_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and bank rotation over 5 lines at width 4
        start_frame(4);
        check_eq("start no valid", 32'(out_valid), 32'd0);
        for (int p = 1; p <= 20; p++) begin
            push(p, 1'b0, 4);
            check_col("fill", p, 4);
        end
        check_eq("p17 col", 32'(exp_col(17, 4)), 32'h09_0D_11);

        // Stall pattern 1,0,0,1: columns unchanged, outputs hold across idle cycles
        start_frame(4);
        for (int p = 1; p <= 12; p++) begin
            push(p, 1'b0, 4);
            check_col("stall", p, 4);
            if (p < 12) begin
                for (int i = 0; i < 2; i++) begin
                    idle();
                    check_eq("stall valid", 32'(out_valid), 32'd0);
                    check_eq("stall hold col", 32'(out_col), 32'(exp_col(p, 4)));
                    check_eq("stall hold x", 32'(out_x), 32'((p - 1) % 4));
                end
            end
        end

        // Width 1: every pixel starts and ends a line
        start_frame(1);
        for (int p = 1; p <= 3; p++) begin
            push(p, 1'b0, 1);
            check_col("w1", p, 1);
        end

        // Width 0 selects MAX_W
        start_frame(0);
        for (int p = 1; p <= 9; p++) begin
            push(p, 1'b0, 0);
            check_col("w0", p, 8);
        end

        // start together with a pixel at x=2
        start_frame(4);
        push(1, 1'b0, 4);
        check_col("mid", 1, 4);
        push(2, 1'b0, 4);
        check_col("mid inflight", 2, 4);
        push(50, 1'b1, 4);
        check_eq("restart valid", 32'(out_valid), 32'd1);
        check_eq("restart col", 32'(out_col), 32'h00_00_32);
        check_eq("restart x", 32'(out_x), 32'd0);
        check_eq("restart sol", 32'(out_sol), 32'd1);
        check_eq("restart rows_ready", 32'(rows_ready), 32'd0);
        push(51, 1'b0, 4);
        push(52, 1'b0, 4);
        push(53, 1'b0, 4);
        check_eq("restart eol", 32'(out_eol), 32'd1);
        push(54, 1'b0, 4);
        check_eq("restart line1 col", 32'(out_col), 32'h00_32_36);
        check_eq("restart line1 x", 32'(out_x), 32'd0);

        // Asynchronous reset between edges
        start_frame(4);
        for (int p = 1; p <= 9; p++) begin
            push(p, 1'b0, 4);
            check_col("prereset", p, 4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async valid", 32'(out_valid), 32'd0);
        check_eq("async rows_ready", 32'(rows_ready), 32'd0);
        check_eq("async col", 32'(out_col), 32'd0);
        check_eq("async x", 32'(out_x), 32'd0);
        rst_n = 1'b1;
        push(77, 1'b0, 4);
        check_eq("post reset valid", 32'(out_valid), 32'd1);
        check_eq("post reset col", 32'(out_col), 32'h00_00_4D);
        check_eq("post reset x", 32'(out_x), 32'd0);
        check_eq("post reset sol", 32'(out_sol), 32'd1);
        check_eq("post reset eol", 32'(out_eol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
